// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register with load-use hazard detection, bubble
//           insertion on flush/stall and a saturating load-use bubble counter.
// Rev     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              RegDst_i,
  input  logic              ALUSrc_i,
  input  logic              MemToReg_i,
  input  logic              RegWrite_i,
  input  logic              MemWrite_i,
  input  logic              MemRead_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [REG_AW-1:0] RSaddr_i,
  input  logic [REG_AW-1:0] RTaddr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] PCplus4_i,
  output logic              stall_o,
  output logic              RegDst_o,
  output logic              ALUSrc_o,
  output logic              MemToReg_o,
  output logic              RegWrite_o,
  output logic              MemWrite_o,
  output logic              MemRead_o,
  output logic [1:0]        ALUOp_o,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [DATA_W-1:0] Imm_o,
  output logic [REG_AW-1:0] RSaddr_o,
  output logic [REG_AW-1:0] RTaddr_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic [DATA_W-1:0] PCplus4_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [1:0] c_ALUOP_BEQ = 2'b01;

  logic w_uses_rt;
  logic w_load_use;
  logic w_bubble;
  logic w_cnt_inc;

  // addi and lw only read rs; R-type, sw and beq also read rt
  assign w_uses_rt  = RegDst_i | MemWrite_i | (ALUOp_i == c_ALUOP_BEQ);
  assign w_load_use = valid_o & MemRead_o & (RTaddr_o != '0) & valid_i &
                      ((RTaddr_o == RSaddr_i) | (w_uses_rt & (RTaddr_o == RTaddr_i)));
  assign stall_o    = w_load_use & ~flush_i;
  assign w_bubble   = flush_i | w_load_use | ~valid_i;
  assign w_cnt_inc  = w_load_use & ~flush_i & (bubble_cnt_o != {CNT_W{1'b1}});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      RegDst_o     <= 1'b0;
      ALUSrc_o     <= 1'b0;
      MemToReg_o   <= 1'b0;
      RegWrite_o   <= 1'b0;
      MemWrite_o   <= 1'b0;
      MemRead_o    <= 1'b0;
      ALUOp_o      <= 2'b00;
      RSdata_o     <= '0;
      RTdata_o     <= '0;
      Imm_o        <= '0;
      RSaddr_o     <= '0;
      RTaddr_o     <= '0;
      RDaddr_o     <= '0;
      PCplus4_o    <= '0;
      valid_o      <= 1'b0;
      bubble_cnt_o <= '0;
    end else if (!hold_i) begin
      if (w_cnt_inc) begin
        bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end
      if (w_bubble) begin
        RegDst_o   <= 1'b0;
        ALUSrc_o   <= 1'b0;
        MemToReg_o <= 1'b0;
        RegWrite_o <= 1'b0;
        MemWrite_o <= 1'b0;
        MemRead_o  <= 1'b0;
        ALUOp_o    <= 2'b00;
        RSdata_o   <= '0;
        RTdata_o   <= '0;
        Imm_o      <= '0;
        RSaddr_o   <= '0;
        RTaddr_o   <= '0;
        RDaddr_o   <= '0;
        PCplus4_o  <= '0;
        valid_o    <= 1'b0;
      end else begin
        RegDst_o   <= RegDst_i;
        ALUSrc_o   <= ALUSrc_i;
        MemToReg_o <= MemToReg_i;
        RegWrite_o <= RegWrite_i;
        MemWrite_o <= MemWrite_i;
        MemRead_o  <= MemRead_i;
        ALUOp_o    <= ALUOp_i;
        RSdata_o   <= RSdata_i;
        RTdata_o   <= RTdata_i;
        Imm_o      <= Imm_i;
        RSaddr_o   <= RSaddr_i;
        RTaddr_o   <= RTaddr_i;
        RDaddr_o   <= RDaddr_i;
        PCplus4_o  <= PCplus4_i;
        valid_o    <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, directly downstream of the main decoder.
- Captures the decoder's control bits plus the ID-stage operands, registers them into EX, and inserts bubbles on branch/jump flush.
- Contains the load-use hazard detector: it drives stall_o back to the PC and IF/ID registers and injects one bubble per detected hazard.
- Keeps a saturating count of load-use bubbles for performance measurement.

Parameters:
DATA_W, 32, datapath width (register data, immediate, PC)
REG_AW, 5, register address width
CNT_W, 16, bubble counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
hold_i  in  1  global freeze; all state holds
flush_i  in  1  taken branch/jump; squash the ID instruction
valid_i  in  1  the ID stage holds a real instruction
RegDst_i, ALUSrc_i, MemToReg_i, RegWrite_i, MemWrite_i, MemRead_i  in  1 each  decoder outputs
ALUOp_i  in  2  decoder ALU op (11 = R-type, 01 = beq, 00 = add)
RSdata_i, RTdata_i  in  DATA_W  register file read data
Imm_i  in  DATA_W  sign-extended immediate; bits [5:0] carry funct for R-type
RSaddr_i, RTaddr_i, RDaddr_i  in  REG_AW  instruction register fields
PCplus4_i  in  DATA_W  PC+4 of the ID instruction
stall_o  out  1  combinational load-use stall to the PC and IF/ID registers
RegDst_o … MemRead_o, ALUOp_o  out  as inputs  registered control
RSdata_o, RTdata_o, Imm_o, RSaddr_o, RTaddr_o, RDaddr_o, PCplus4_o  out  as inputs  registered data
valid_o  out  1  the EX stage holds a real instruction
bubble_cnt_o  out  CNT_W  saturating load-use bubble count

Behaviour:
- Reset: rst_i high clears every registered output to 0 immediately, including valid_o and bubble_cnt_o. Reset asserted mid-operation drops the in-flight instruction.
- uses_rt = RegDst_i | MemWrite_i | (ALUOp_i == 2'b01), i.e. the instruction is R-type, sw or beq. addi and lw do not read rt.
- load_use = valid_o & MemRead_o & (RTaddr_o != 0) & valid_i & ((RTaddr_o == RSaddr_i) | (uses_rt & RTaddr_o == RTaddr_i)).
- stall_o = load_use & ~flush_i. It is purely combinational from current registers and inputs, with no added latency.
- Per-edge priority, highest first:
  1. hold_i = 1: all registers keep their values; the counter does not change.
  2. flush_i = 1, load_use = 1, or valid_i = 0: load a bubble.
     - valid_o <= 0; all control outputs <= 0; ALUOp_o <= 00.
     - All data and address fields <= 0.
  3. Otherwise: load every _i field into its _o; valid_o <= 1.
- Bubble counter increments by 1 on a non-held edge where load_use = 1 and flush_i = 0.
  - It saturates at 2^CNT_W − 1; there is no wrap-around.
  - Flush bubbles and valid_i = 0 bubbles are not counted.
- Simultaneous flush_i and load_use: a single bubble is inserted, stall_o = 0, the counter is unchanged.
- Latency: one cycle, ID inputs to EX outputs.
- A load-use hazard costs exactly one bubble. On the next cycle MemRead_o = 0, so load_use deasserts and the stalled instruction advances.
- A lw targeting $0 never stalls.
- An unknown ALUOp_i (xx) on a valid instruction is passed through unchanged. On a bubble, ALUOp_o is forced to 00.

Test Plan:
- Reset: drive rst_i high mid-stream without a clock edge → all outputs 0 immediately; after release with valid_i = 1, addi inputs (RSaddr 3, Imm 5) → next edge RSaddr_o = 3, Imm_o = 5, ALUSrc_o = 1, valid_o = 1.
- Load-use: lw $2 in EX (MemRead_o = 1, RTaddr_o = 2) and add rs = 2 in ID → stall_o = 1; next edge valid_o = 0, controls 0, bubble_cnt_o = 1; following edge add loaded with RegDst_o = 1, ALUOp_o = 11.
- rt not read: lw $2 in EX and addi rt = 2, rs = 4 in ID → stall_o = 0, no bubble. Same case with sw rt = 2 → stall_o = 1.
- $0 and flush: lw $0 in EX, add rs = 0 → no stall. lw $2 in EX with flush_i = 1 and a dependent ID instruction → stall_o = 0, bubble inserted, count unchanged.
- Hold: with hold_i = 1 for 3 cycles while inputs change → outputs and count frozen; on release the next edge loads the current inputs.
- Saturation: with CNT_W = 2, force 5 load-use bubbles → bubble_cnt_o reads 1, 2, 3, 3, 3.
